// File: rtl/zigzag_pkg.sv
// Shared types and scan-order helpers for the zigzag reorder buffer.
package zigzag_pkg;

    typedef enum logic [1:0] {
        ZZ        = 2'd0,
        RASTER    = 2'd1,
        TRANSPOSE = 2'd2
    } mode_e;

    // JPEG zigzag position of each raster location, indexed by {row, col}.
    localparam logic [5:0] ZZ_TAB [0:63] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    function automatic logic [5:0] zz_scan(input logic [2:0] row, input logic [2:0] col);
        return ZZ_TAB[{row, col}];
    endfunction

    // Scan index at which coefficient (row, col) is stored; encoding 3 behaves as raster.
    function automatic logic [5:0] scan_addr(input logic [1:0] mode, input logic [2:0] row,
                                             input logic [2:0] col);
        logic [5:0] addr;
        case (mode_e'(mode))
            ZZ:        addr = zz_scan(row, col);
            TRANSPOSE: addr = {col, row};
            default:   addr = {row, col};
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/zigzag_reorder_if.sv
// Row-input / scan-output bundle of the zigzag reorder buffer.
interface zigzag_reorder_if #(
    parameter int QW        = 15,
    parameter int OUT_LANES = 2,
    parameter int NBLK      = 2
);
    localparam int LW = $clog2(NBLK) + 1;

    logic [7:0][QW-1:0]         d;
    logic [2:0]                 d_cnt;
    logic                       d_valid;
    logic                       d_hold;
    logic [1:0]                 mode;
    logic [OUT_LANES-1:0][QW-1:0] q;
    logic [5:0]                 q_cnt;
    logic                       q_last;
    logic                       q_valid;
    logic                       q_hold;
    logic [LW-1:0]              level;

    // Reorder buffer side.
    modport slave (
        input  d, d_cnt, d_valid, mode, q_hold,
        output d_hold, q, q_cnt, q_last, q_valid, level
    );

    // Source / sink side.
    modport master (
        output d, d_cnt, d_valid, mode, q_hold,
        input  d_hold, q, q_cnt, q_last, q_valid, level
    );
endinterface

// File: rtl/zigzag_slot_mem.sv
// Block slot storage: IN_LANES scattered writes, one aligned OUT_LANES-wide read.
// A read of a location written in the same cycle returns the new data so that
// a block committing on the cycle it is first needed can be read without a bubble.
module zigzag_slot_mem #(
    parameter int QW        = 15,
    parameter int IN_LANES  = 2,
    parameter int OUT_LANES = 2,
    parameter int NBLK      = 2
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(NBLK)-1:0]       wr_slot,
    input  logic [IN_LANES-1:0][5:0]      wr_addr,
    input  logic [IN_LANES-1:0][QW-1:0]   wr_data,
    input  logic [$clog2(NBLK)-1:0]       rd_slot,
    input  logic [$clog2(64/OUT_LANES)-1:0] rd_beat,
    output logic [OUT_LANES-1:0][QW-1:0]  rd_data
);
    logic [QW-1:0]               mem_q [NBLK*64];
    logic [OUT_LANES-1:0][5:0]   rd_addr_s;

    // Scatter the incoming lanes into the selected slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int w = 0; w < IN_LANES; w++) begin
                mem_q[{wr_slot, wr_addr[w]}] <= wr_data[w];
            end
        end
    end

    // Scan addresses covered by the current read beat.
    always_comb begin
        rd_addr_s = '0;
        for (int l = 0; l < OUT_LANES; l++) begin
            rd_addr_s[l] = 6'((int'(rd_beat) * OUT_LANES) + l);
        end
    end

    // Aligned read with same-cycle write forwarding.
    always_comb begin
        rd_data = '0;
        for (int l = 0; l < OUT_LANES; l++) begin
            rd_data[l] = mem_q[{rd_slot, rd_addr_s[l]}];
            for (int w = 0; w < IN_LANES; w++) begin
                if (wr_en && (wr_slot == rd_slot) && (wr_addr[w] == rd_addr_s[l])) begin
                    rd_data[l] = wr_data[w];
                end
            end
        end
    end
endmodule

// File: rtl/zigzag_reorder.sv
// Zigzag reorder buffer: collects 8x8 blocks row by row into NBLK slots and
// streams each block in its selected scan order, OUT_LANES coefficients per beat.
module zigzag_reorder
    import zigzag_pkg::*;
#(
    parameter int QW        = 15,
    parameter int IN_LANES  = 2,
    parameter int OUT_LANES = 2,
    parameter int NBLK      = 2
) (
    input  logic            clk,
    input  logic            resetn,
    zigzag_reorder_if.slave bus
);
    localparam int ROW_BEATS = 8 / IN_LANES;
    localparam int BLK_BEATS = 64 / OUT_LANES;
    localparam int SW        = $clog2(NBLK);
    localparam int WBW       = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int RBW       = $clog2(BLK_BEATS);
    localparam int LW        = $clog2(NBLK) + 1;
    localparam int OLW       = $clog2(OUT_LANES);

    logic [SW-1:0]                wptr_q, wptr_d;
    logic [SW-1:0]                rptr_q, rptr_d;
    logic [WBW-1:0]               wbeat_q, wbeat_d;
    logic [RBW-1:0]               rbeat_q, rbeat_d;
    logic [LW-1:0]                level_q, level_d;
    logic                         q_valid_q, q_valid_d;
    logic                         q_last_q, q_last_d;
    logic [5:0]                   q_cnt_q, q_cnt_d;
    logic [OUT_LANES-1:0][QW-1:0] q_data_q, q_data_d;
    logic [NBLK-1:0][1:0]         slot_mode_q, slot_mode_d;

    logic                         full_s, wbeat_last_s, consume_s, first_s, commit_s;
    logic                         xfer_s, release_s, load_s, avail_s;
    logic [1:0]                   wmode_s;
    logic [SW-1:0]                rd_slot_s;
    logic [IN_LANES-1:0][2:0]     wr_col_s;
    logic [IN_LANES-1:0][5:0]     wr_addr_s;
    logic [IN_LANES-1:0][QW-1:0]  wr_data_s;
    logic [OUT_LANES-1:0][QW-1:0] rd_data_s;

    assign full_s       = (level_q == LW'(NBLK));
    assign wbeat_last_s = (wbeat_q == WBW'(ROW_BEATS - 1));
    assign consume_s    = bus.d_valid & ~full_s;
    assign first_s      = (wbeat_q == '0) & (bus.d_cnt == 3'd0);
    assign commit_s     = consume_s & wbeat_last_s & (bus.d_cnt == 3'd7);
    // The first sub-beat of a block uses the live mode; later ones the latched one.
    assign wmode_s      = first_s ? bus.mode : slot_mode_q[wptr_q];

    assign xfer_s       = q_valid_q & ~bus.q_hold;
    assign release_s    = xfer_s & q_last_q;
    assign load_s       = ~q_valid_q | ~bus.q_hold;
    // Data remains once this cycle's release is accounted for; a commit landing on
    // the releasing cycle is already readable through the memory's write forwarding.
    assign avail_s      = ((level_q - LW'(release_s)) != '0) | (release_s & commit_s);
    assign rd_slot_s    = release_s ? (rptr_q + SW'(1)) : rptr_q;

    assign bus.d_hold   = full_s | ~wbeat_last_s;
    assign bus.q        = q_data_q;
    assign bus.q_cnt    = q_cnt_q;
    assign bus.q_last   = q_last_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.level    = level_q;

    // Column, scan address and data of each write lane for the current sub-beat.
    always_comb begin
        wr_col_s  = '0;
        wr_addr_s = '0;
        wr_data_s = '0;
        for (int l = 0; l < IN_LANES; l++) begin
            wr_col_s[l]  = 3'((int'(wbeat_q) * IN_LANES) + l);
            wr_addr_s[l] = scan_addr(wmode_s, bus.d_cnt, wr_col_s[l]);
            wr_data_s[l] = bus.d[wr_col_s[l]];
        end
    end

    zigzag_slot_mem #(
        .QW        (QW),
        .IN_LANES  (IN_LANES),
        .OUT_LANES (OUT_LANES),
        .NBLK      (NBLK)
    ) u_mem (
        .clk     (clk),
        .wr_en   (consume_s),
        .wr_slot (wptr_q),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_slot (rd_slot_s),
        .rd_beat (rbeat_q),
        .rd_data (rd_data_s)
    );

    // Next-state for write side, occupancy and the output register.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        wbeat_d     = wbeat_q;
        rbeat_d     = rbeat_q;
        q_valid_d   = q_valid_q;
        q_last_d    = q_last_q;
        q_cnt_d     = q_cnt_q;
        q_data_d    = q_data_q;
        slot_mode_d = slot_mode_q;
        level_d     = level_q + LW'(commit_s) - LW'(release_s);

        if (consume_s) begin
            if (wbeat_last_s) begin
                wbeat_d = '0;
            end else begin
                wbeat_d = wbeat_q + WBW'(1);
            end
            if (first_s) begin
                slot_mode_d[wptr_q] = bus.mode;
            end else begin
                slot_mode_d = slot_mode_q;
            end
        end else begin
            wbeat_d = wbeat_q;
        end

        if (commit_s) begin
            wptr_d = wptr_q + SW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (release_s) begin
            rptr_d = rptr_q + SW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        if (load_s) begin
            q_valid_d = avail_s;
            if (avail_s) begin
                q_data_d = rd_data_s;
                q_cnt_d  = 6'(rbeat_q) << OLW;
                q_last_d = (rbeat_q == RBW'(BLK_BEATS - 1));
                rbeat_d  = rbeat_q + RBW'(1);
            end else begin
                rbeat_d  = rbeat_q;
            end
        end else begin
            q_valid_d = q_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wbeat_q     <= '0;
            rbeat_q     <= '0;
            level_q     <= '0;
            q_valid_q   <= 1'b0;
            q_last_q    <= 1'b0;
            q_cnt_q     <= 6'd0;
            q_data_q    <= '0;
            slot_mode_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wbeat_q     <= wbeat_d;
            rbeat_q     <= rbeat_d;
            level_q     <= level_d;
            q_valid_q   <= q_valid_d;
            q_last_q    <= q_last_d;
            q_cnt_q     <= q_cnt_d;
            q_data_q    <= q_data_d;
            slot_mode_q <= slot_mode_d;
        end
    end
endmodule
